cp0_exc: RTL

- Coprocessor-0 for the five-stage MIPS core.
- Consumes the exception cause word that the decode-stage exception control produces and that the pipeline carries to M. It also takes the six external hardware interrupt lines.
- Decides whether an exception or interrupt is taken at the M stage, holds SR/Cause/EPC/PRId, and serves mfc0/mtc0/eret.
- Its int_req output flushes the pipeline and redirects fetch to the handler.

---
 rtl/cp0_exc.sv | 96 +++++++++
 1 files changed

// File: rtl/cp0_exc.sv
// Coprocessor 0: takes exceptions and interrupts at M, and holds SR, Cause, EPC and PRId for mfc0, mtc0 and eret.
// Latency: int_req, exc_pc and dout are combinational; state updates at the next clk edge; hwint reaches Cause.IP one cycle late.
// Backpressure: none. int_req flushes F-M directly and drops any mtc0 or eret in the same cycle.
module cp0_exc #(
    parameter logic [31:0] PRID    = 32'h0000_4A11,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic        we,
    input  logic        eret_m,
    input  logic [31:0] pc_m,
    input  logic [31:0] cause_m,
    input  logic [5:0]  hwint,
    output logic [31:0] dout,
    output logic        int_req,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  srIm;
    logic        srExl;
    logic        srIe;
    logic        causeBd;
    logic [4:0]  excCode;
    logic [31:0] epc;
    logic [5:0]  hwintQ;
    logic        irq;
    logic        exc;
    logic        takeExc;
    logic [31:0] rdData;
    logic        unusedCauseBits;

    assign unusedCauseBits = ^{cause_m[30:7], cause_m[1:0]};

    assign irq     = (|(hwintQ & srIm)) & srIe & ~srExl;
    assign exc     = (cause_m[6:2] != 5'd0) & ~srExl;
    // Gated by reset so that no flush is requested while the core is held in reset.
    assign takeExc = (irq | exc) & reset;

    assign int_req = takeExc;
    assign exc_pc  = takeExc ? HANDLER : epc;
    assign epc_out = epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srIm    <= 6'd0;
            srExl   <= 1'b0;
            srIe    <= 1'b0;
            causeBd <= 1'b0;
            excCode <= 5'd0;
            epc     <= 32'd0;
            hwintQ  <= 6'd0;
        end else begin
            hwintQ <= hwint;
            if (takeExc) begin
                srExl   <= 1'b1;
                causeBd <= cause_m[31];
                epc     <= cause_m[31] ? (pc_m - 32'd4) : pc_m;
                excCode <= irq ? 5'd0 : cause_m[6:2];
            end else begin
                if (eret_m) begin
                    srExl <= 1'b0;
                end
                if (we) begin
                    case (addr)
                        5'd12: begin
                            srIm  <= din[15:10];
                            srExl <= din[1];
                            srIe  <= din[0];
                        end
                        5'd14:   epc <= {din[31:2], 2'b00};
                        default: ;
                    endcase
                end
            end
        end
    end

    // Reads return registered state only: a mtc0 in the same cycle is not bypassed.
    always_comb begin
        rdData = 32'd0;
        case (addr)
            5'd12:   rdData = {16'b0, srIm, 8'b0, srExl, srIe};
            5'd13:   rdData = {causeBd, 15'b0, hwintQ, 3'b0, excCode, 2'b0};
            5'd14:   rdData = epc;
            5'd15:   rdData = PRID;
            default: rdData = 32'd0;
        endcase
    end

    assign dout = reset ? rdData : 32'd0;

endmodule
